ir_command_sequencer: RTL
=========================

Name: ir_command_sequencer

Overview:
- Bus-mapped timed command queue. Sits directly upstream of the IR transmitter wrapper; its COMMAND_OUT feeds the wrapper's 4-bit drive command.
- The microprocessor queues (command, duration) entries over the shared bus. The block plays them back in order: each command is held for a programmed number of 100 ms ticks.
- When the queue drains, the block drives STOP (4'b0000) and raises an interrupt.

Parameters:
- BASE_ADDR, 8'h94, base bus address; block decodes BASE_ADDR+0..+2.
- DEPTH, 8, FIFO entries (power of 2, 2..16).
- TICK_DIV, 5000000, CLK cycles per duration tick (100 ms at 50 MHz).

Ports:
- CLK  input  1  system clock.
- RST  input  1  reset, synchronous, active-low.
- ADDR_IN  input  8  bus address.
- BUS_WE  input  1  bus write enable.
- DATA_IN  input  8  bus write data.
- BUS_DATA_OUT  output  8  read data (status register).
- BUS_DATA_OUT_EN  output  1  high when this block drives the bus.
- COMMAND_OUT  output  4  registered drive command to IR transmitter.
- BUSY  output  1  high in LOAD/RUN.
- INTERRUPT_RAISE  output  1  level, queue-drained interrupt.
- INTERRUPT_ACK  input  1  clears INTERRUPT_RAISE.

Behaviour:
- Reset (RST==0 at posedge):
  - FIFO emptied; state IDLE.
  - COMMAND_OUT=0, BUSY=0, INTERRUPT_RAISE=0.
  - Overflow and pause flags cleared; tick counter cleared.
  - Reset mid-RUN aborts immediately.
- Register map:
  - BASE+0 write: push entry. DATA_IN[3:0]=command, DATA_IN[7:4]=duration in ticks; duration 0 is treated as 16.
  - BASE+1 write: control. bit0=flush (self-clearing action); bit1=pause (persistent level, written each time).
  - BASE+2 read (ADDR_IN==BASE+2 && !BUS_WE): BUS_DATA_OUT_EN=1 combinationally, else 0.
  - BUS_DATA_OUT={count[3:0], overflow, pause, full, empty}. It is driven from current registers and is 8'h00 when not enabled.
- FIFO:
  - Push when full: the entry is dropped and the sticky overflow flag is set. Only flush or reset clears overflow.
  - Full is evaluated before any same-cycle pop, so push-at-full is dropped even if a pop occurs that cycle.
  - Simultaneous push and pop (not full): both occur; count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: COMMAND_OUT=0. If !empty && !pause, pop the head entry and go to LOAD.
  - LOAD (1 cycle): latch command/duration into the active registers; tick counter=0; go to RUN.
  - RUN:
    - COMMAND_OUT=active command, registered; valid from the first RUN cycle.
    - Tick counter counts 0..TICK_DIV-1. On reaching TICK_DIV-1 it wraps to 0 and remaining decrements.
    - When remaining reaches 0: if !empty && !pause, pop and go to LOAD (no STOP gap beyond the LOAD cycle, where COMMAND_OUT holds the old value). Otherwise go to DONE.
  - DONE (1 cycle): COMMAND_OUT=0; set INTERRUPT_RAISE; go to IDLE.
- Timing:
  - From the write edge of a push into an empty IDLE block, COMMAND_OUT updates on the 3rd following rising edge.
  - A duration of N holds the command for exactly N*TICK_DIV cycles of RUN.
- Pause:
  - Pause asserted in RUN freezes the tick counter and remaining, and forces COMMAND_OUT=0.
  - Pause deasserted resumes with the same remaining time and restores the command.
  - Pause in IDLE blocks popping.
- Flush in any state: FIFO emptied, overflow cleared, next state IDLE, COMMAND_OUT=0 on the next edge, no interrupt raised.
- Push and flush cannot coincide (different addresses).
- Interrupt:
  - INTERRUPT_RAISE stays high until INTERRUPT_ACK is sampled high.
  - If ACK coincides with a new set in DONE, the set wins.
- BUSY=1 in LOAD and RUN, 0 otherwise.

Test Plan:
- TICK_DIV=10, reset then write BASE+0=8'h31 -> COMMAND_OUT=4'h1 on the 3rd edge after the write, held 30 cycles, then 0. INTERRUPT_RAISE=1 until ACK; status read after the drain = 8'h01.
- Push 8'h21, 8'h12, 8'h14 back-to-back -> COMMAND_OUT sequence 1 (20 cycles), 2 (10), 4 (10) with only single LOAD cycles between; one interrupt at the end.
- Push 9 entries with DEPTH=8 -> 9th dropped; status read = 8'h8A (count=8, overflow, full); only 8 commands play.
- Entry 8'h51 with pause written at tick 2 for 25 cycles -> COMMAND_OUT=0 during pause. On resume, command 1 returns, and total RUN time excluding the pause is 50 cycles.
- Flush (BASE+1=8'h01) mid-RUN with 3 queued -> COMMAND_OUT=0 next edge, state IDLE, status=8'h01, no interrupt.
- RST low mid-RUN -> all outputs 0 at the next edge; queue empty after release.

Source files
------------

// File: rtl/ir_command_sequencer.sv
// Timed IR command queue: the bus loads (command, duration) entries and the block
// replays them in order, holding each command for a number of 100 ms ticks.
module ir_command_sequencer #(
    parameter logic [7:0] BASE_ADDR = 8'h94,
    parameter int         DEPTH     = 8,
    parameter int         TICK_DIV  = 5000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] ADDR_IN,
    input  logic       BUS_WE,
    input  logic [7:0] DATA_IN,
    output logic [7:0] BUS_DATA_OUT,
    output logic       BUS_DATA_OUT_EN,
    output logic [3:0] COMMAND_OUT,
    output logic       BUSY,
    output logic       INTERRUPT_RAISE,
    input  logic       INTERRUPT_ACK
);

    // state | meaning
    // IDLE  | drive STOP, pop the head entry when queue non-empty and not paused
    // LOAD  | move the popped entry into the active registers, arm the timers
    // RUN   | drive the active command, count ticks and remaining duration
    // DONE  | queue drained: drive STOP and raise the interrupt
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [3:0]    count_lo;
    logic          overflow;
    logic          pause_q;
    logic [7:0]    head_q;
    logic          full;
    logic          empty;

    state_t        state;
    logic [3:0]    active_cmd;
    logic [4:0]    remaining;
    logic [TW-1:0] tick;

    logic          push_wr;
    logic          ctrl_wr;
    logic          flush;
    logic          rd_sel;
    logic          push_ok;
    logic          pop;
    logic          run_end;

    // register-file address decode
    assign push_wr = BUS_WE && (ADDR_IN == BASE_ADDR);
    assign ctrl_wr = BUS_WE && (ADDR_IN == BASE_ADDR + 8'd1);
    assign rd_sel  = !BUS_WE && (ADDR_IN == BASE_ADDR + 8'd2);
    assign flush   = ctrl_wr && DATA_IN[0];

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign count_lo = 4'(count);

    assign BUS_DATA_OUT_EN = rd_sel;
    assign BUS_DATA_OUT    = rd_sel ? {count_lo, overflow, pause_q, full, empty} : 8'h00;

    // full is taken from the registered count, so a push at full drops even if a pop happens
    assign push_ok = push_wr && !full;
    assign run_end = (tick == '0) && (remaining == 5'd1);
    assign pop     = !flush && !pause_q && !empty &&
                     ((state == S_IDLE) || ((state == S_RUN) && run_end));

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= DATA_IN;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            pause_q  <= 1'b0;
            head_q   <= 8'h00;
        end else begin
            if (ctrl_wr) begin
                pause_q <= DATA_IN[1];
            end
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                if (push_wr && full) begin
                    overflow <= 1'b1;
                end
                if (push_ok) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                    head_q <= mem[rd_ptr];
                end
                case ({push_ok, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state           <= S_IDLE;
            COMMAND_OUT     <= 4'h0;
            BUSY            <= 1'b0;
            INTERRUPT_RAISE <= 1'b0;
            active_cmd      <= 4'h0;
            remaining       <= 5'd0;
            tick            <= '0;
        end else begin
            if (INTERRUPT_ACK) begin
                INTERRUPT_RAISE <= 1'b0;
            end
            if (flush) begin
                state       <= S_IDLE;
                COMMAND_OUT <= 4'h0;
                BUSY        <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        COMMAND_OUT <= 4'h0;
                        if (pop) begin
                            state <= S_LOAD;
                            BUSY  <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        active_cmd <= head_q[3:0];
                        remaining  <= (head_q[7:4] == 4'h0) ? 5'd16 : {1'b0, head_q[7:4]};
                        tick       <= TICK_LAST;
                        state      <= S_RUN;
                    end
                    S_RUN: begin
                        COMMAND_OUT <= pause_q ? 4'h0 : active_cmd;
                        if (!pause_q) begin
                            if (run_end) begin
                                if (pop) begin
                                    state <= S_LOAD;
                                end else begin
                                    state <= S_DONE;
                                    BUSY  <= 1'b0;
                                end
                            end else if (tick == '0) begin
                                remaining <= remaining - 5'd1;
                                tick      <= TICK_LAST;
                            end else begin
                                tick <= tick - TW'(1);
                            end
                        end
                    end
                    S_DONE: begin
                        COMMAND_OUT     <= 4'h0;
                        INTERRUPT_RAISE <= 1'b1;
                        state           <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
